// File: rtl/demux_8_reg_if.sv
// -----------------------------------------------------------------------------
// demux_8_reg_if
//   Bus bundle for the registered 1-to-8 demultiplexer.
//
//   Producer side (master drives, slave receives):
//     E     [INPUT_BITS-1:0] data word to distribute
//     S     [2:0]            manual channel select (used when auto = 0)
//     load                   write strobe
//     auto                   1: target = internal pointer, 0: target = S
//     clr                    synchronous clear of valid flags and pointer
//
//   Consumer side (slave drives, master receives):
//     F0..F7 [INPUT_BITS-1:0] holding registers for channels 0..7
//     V     [7:0]             per-channel valid flags (bit i <-> Fi)
//     ptr   [2:0]             auto-mode pointer
//     full                    all eight channels valid
//     done                    one-cycle pulse after the channel set completes
// -----------------------------------------------------------------------------
interface demux_8_reg_if #(
    parameter int INPUT_BITS = 2
);
    logic [INPUT_BITS-1:0] E;
    logic [2:0]            S;
    logic                  load;
    logic                  auto;
    logic                  clr;

    logic [INPUT_BITS-1:0] F0;
    logic [INPUT_BITS-1:0] F1;
    logic [INPUT_BITS-1:0] F2;
    logic [INPUT_BITS-1:0] F3;
    logic [INPUT_BITS-1:0] F4;
    logic [INPUT_BITS-1:0] F5;
    logic [INPUT_BITS-1:0] F6;
    logic [INPUT_BITS-1:0] F7;
    logic [7:0]            V;
    logic [2:0]            ptr;
    logic                  full;
    logic                  done;

    // Producer / environment view.
    modport master (
        output E, S, load, auto, clr,
        input  F0, F1, F2, F3, F4, F5, F6, F7, V, ptr, full, done
    );

    // Demultiplexer view.
    modport slave (
        input  E, S, load, auto, clr,
        output F0, F1, F2, F3, F4, F5, F6, F7, V, ptr, full, done
    );
endinterface : demux_8_reg_if

// File: rtl/demux_8_reg.sv
// -----------------------------------------------------------------------------
// demux_8_reg
//   Registered 1-to-8 demultiplexer. An input word is written into one of
//   eight holding registers, addressed either by the explicit select S or by an
//   internal auto-incrementing pointer. Per-channel valid flags track which
//   channels hold fresh data; once all eight are valid the block locks out
//   further writes until clr, and pulses done for one cycle.
//
//   Ports:
//     clk   rising-edge system clock
//     rst   asynchronous, active-high reset
//     bus   demux_8_reg_if.slave (E, S, load, auto, clr in;
//                                 F0..F7, V, ptr, full, done out)
//
//   Timing: written data appears on Fi the cycle after the accepting edge.
// -----------------------------------------------------------------------------
module demux_8_reg #(
    parameter int INPUT_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    demux_8_reg_if.slave      bus
);

    // -------------------------------------------------------------------------
    // Types and state
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,   // V == 0
        ST_FILLING = 2'd1,   // some, not all, channels valid
        ST_FULL    = 2'd2    // V == 8'hFF, writes locked out until clr
    } state_e;

    typedef logic [INPUT_BITS-1:0] word_t;

    localparam logic [7:0] ALL_VALID = 8'hFF;

    state_e     state_q, state_d;
    word_t      f_q [8];
    logic [7:0] v_q, v_d;
    logic [2:0] ptr_q, ptr_d;
    logic       done_q, done_d;

    logic [2:0] target;     // channel addressed by the current cycle
    logic       accept;     // a write is taken on the coming edge
    logic [7:0] wr_sel;     // one-hot write enable for the holding registers

    // In auto mode the pointer addresses the channel and S is don't-care.
    assign target = bus.auto ? ptr_q : bus.S;

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked blocks use non-blocking (<=) so every register samples the
    // pre-edge values of its neighbours; blocking here would create ordering
    // dependent simulation races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default at the top of the block
    // so no path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        if (bus.clr) begin
            // clr wins over any simultaneous load, from every state.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    // A single write sets exactly one bit, so FULL is never
                    // reachable directly from EMPTY.
                    if (accept) begin
                        state_d = ST_FILLING;
                    end
                end
                ST_FILLING: begin
                    if (accept && (v_d == ALL_VALID)) begin
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    state_d = ST_FULL;
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 3: output / datapath decode
    // -------------------------------------------------------------------------
    always_comb begin
        accept = 1'b0;
        wr_sel = 8'h00;
        v_d    = v_q;
        ptr_d  = ptr_q;
        done_d = 1'b0;

        unique case (state_q)
            ST_EMPTY,
            ST_FILLING: accept = bus.load & ~bus.clr;
            default:    accept = 1'b0;   // FULL ignores load
        endcase

        if (bus.clr) begin
            // F contents are intentionally kept; only bookkeeping is cleared.
            v_d   = 8'h00;
            ptr_d = 3'd0;
        end else if (accept) begin
            wr_sel = 8'h01 << target;
            // Overwriting an already valid channel leaves its bit at 1.
            v_d    = v_q | wr_sel;
            if (bus.auto) begin
                // 3-bit add wraps 7 -> 0 naturally.
                ptr_d = ptr_q + 3'd1;
            end
            // Only an accepted write can complete the set, and writes are
            // refused once FULL, so done cannot re-fire while held FULL.
            done_d = (v_d == ALL_VALID);
        end
    end

    // -------------------------------------------------------------------------
    // Bookkeeping registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= 8'h00;
            ptr_q  <= 3'd0;
            done_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            ptr_q  <= ptr_d;
            done_q <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Holding registers
    // -------------------------------------------------------------------------
    // NOTE: this small register array is reset on purpose because consumers
    // see all eight words in parallel and must read zeros after reset; larger
    // storage would normally be left unreset so it can map onto RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                f_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_sel[i]) begin
                    f_q[i] <= bus.E;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.F0   = f_q[0];
    assign bus.F1   = f_q[1];
    assign bus.F2   = f_q[2];
    assign bus.F3   = f_q[3];
    assign bus.F4   = f_q[4];
    assign bus.F5   = f_q[5];
    assign bus.F6   = f_q[6];
    assign bus.F7   = f_q[7];
    assign bus.V    = v_q;
    assign bus.ptr  = ptr_q;
    assign bus.full = (v_q == ALL_VALID);
    assign bus.done = done_q;

endmodule : demux_8_reg

// File: tb/tb_demux_8_reg.sv
// -----------------------------------------------------------------------------
// tb_demux_8_reg
//   Self-checking bench for demux_8_reg (INPUT_BITS = 2). A behavioural model
//   tracks the eight words, the valid set, the pointer and the done pulse;
//   "full" is simply "every channel valid".
// -----------------------------------------------------------------------------
module tb_demux_8_reg;

    localparam int W = 2;

    logic clk;
    logic rst;

    demux_8_reg_if #(.INPUT_BITS(W)) bus ();

    demux_8_reg #(.INPUT_BITS(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- counters
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    logic [W-1:0] mf [8];
    bit           mv [8];
    int           mptr;
    bit           mdone;

    function automatic bit m_all_valid();
        for (int i = 0; i < 8; i++) if (!mv[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] m_vmask();
        logic [7:0] m = '0;
        for (int i = 0; i < 8; i++) m[i] = mv[i];
        return m;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            mf[i] = '0;
            mv[i] = 1'b0;
        end
        mptr  = 0;
        mdone = 1'b0;
    endtask

    // One clock edge of the specified behaviour.
    task automatic m_step(input bit ld, input bit au, input bit cl,
                          input int s, input logic [W-1:0] e);
        int t;
        mdone = 1'b0;
        if (cl) begin
            for (int i = 0; i < 8; i++) mv[i] = 1'b0;
            mptr = 0;
        end else if (ld && !m_all_valid()) begin
            t      = au ? mptr : s;
            mf[t]  = e;
            mv[t]  = 1'b1;
            if (au) mptr = (mptr + 1) % 8;
            mdone  = m_all_valid();
        end
    endtask

    // --------------------------------------------------------------- helpers
    function automatic logic [W-1:0] get_f(input int i);
        case (i)
            0: return bus.F0;
            1: return bus.F1;
            2: return bus.F2;
            3: return bus.F3;
            4: return bus.F4;
            5: return bus.F5;
            6: return bus.F6;
            default: return bus.F7;
        endcase
    endfunction

    task automatic compare_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s F%0d", tag, i), 32'(get_f(i)), 32'(mf[i]));
        end
        check({tag, " V"},    32'(bus.V),    32'(m_vmask()));
        check({tag, " ptr"},  32'(bus.ptr),  32'(mptr));
        check({tag, " full"}, 32'(bus.full), 32'(m_all_valid()));
        check({tag, " done"}, 32'(bus.done), 32'(mdone));
    endtask

    // Drive one cycle's inputs, advance across the edge, land 1 ns after it.
    task automatic drive(input bit ld, input bit au, input bit cl,
                         input logic [2:0] s, input logic [W-1:0] e);
        bus.load = ld;
        bus.auto = au;
        bus.clr  = cl;
        bus.S    = s;
        bus.E    = e;
        @(posedge clk);
        m_step(ld, au, cl, int'(s), e);
        #1;
    endtask

    // ------------------------------------------------------------ vector table
    typedef struct {
        string        name;
        bit           ld;
        bit           au;
        bit           cl;
        logic [2:0]   s;
        logic [W-1:0] e;
        logic [7:0]   exp_v;
        logic [2:0]   exp_ptr;
        bit           exp_full;
        bit           exp_done;
    } vec_t;

    vec_t vecs [11];

    // ------------------------------------------------------------------- test
    initial begin
        rst      = 1'b1;
        bus.E    = '0;
        bus.S    = '0;
        bus.load = 1'b0;
        bus.auto = 1'b0;
        bus.clr  = 1'b0;
        m_reset();

        // Auto fill: E = 0,1,2,3,0,1,2,3 into channels 0..7.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{$sformatf("fill%0d", i), 1'b1, 1'b1, 1'b0, 3'd0,
                        W'(i % 4), 8'((16'h1 << (i + 1)) - 1), 3'((i + 1) % 8),
                        (i == 7), (i == 7)};
        end
        // Idle while FULL: done drops after one cycle and stays low.
        vecs[8]  = '{"idle_full", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 8'hFF, 3'd0, 1'b1, 1'b0};
        // Lockout: manual write of 3 to ch0 must be ignored.
        vecs[9]  = '{"lockout",   1'b1, 1'b0, 1'b0, 3'd0, 2'd3, 8'hFF, 3'd0, 1'b1, 1'b0};
        // clr returns to EMPTY with data retained.
        vecs[10] = '{"clr_full",  1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 8'h00, 3'd0, 1'b0, 1'b0};

        // ---- reset state
        #2;
        compare_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---- reset mid-operation, asserted between edges
        drive(1, 1, 0, 3'd0, 2'd3);
        drive(1, 1, 0, 3'd0, 2'd2);
        drive(1, 1, 0, 3'd0, 2'd1);
        compare_all("pre_rst");
        #2 rst = 1'b1;
        #1;
        m_reset();
        check("async_rst V",    32'(bus.V),   32'h0);
        check("async_rst ptr",  32'(bus.ptr), 32'h0);
        check("async_rst F0",   32'(bus.F0),  32'h0);
        check("async_rst done", 32'(bus.done), 32'h0);
        compare_all("async_rst");
        #1 rst = 1'b0;

        // ---- table: auto fill, FULL lockout, clr
        for (int k = 0; k < 11; k++) begin
            drive(vecs[k].ld, vecs[k].au, vecs[k].cl, vecs[k].s, vecs[k].e);
            check({vecs[k].name, " V"},    32'(bus.V),    32'(vecs[k].exp_v));
            check({vecs[k].name, " ptr"},  32'(bus.ptr),  32'(vecs[k].exp_ptr));
            check({vecs[k].name, " full"}, 32'(bus.full), 32'(vecs[k].exp_full));
            check({vecs[k].name, " done"}, 32'(bus.done), 32'(vecs[k].exp_done));
            compare_all(vecs[k].name);
        end
        // Data retained through lockout and clr.
        for (int i = 0; i < 8; i++) begin
            check($sformatf("retain F%0d", i), 32'(get_f(i)), 32'(i % 4));
        end

        // ---- manual overwrite of channel 5
        drive(1, 0, 0, 3'd5, 2'd1);
        drive(1, 0, 0, 3'd5, 2'd2);
        check("ovw F5",   32'(bus.F5),   32'd2);
        check("ovw V",    32'(bus.V),    32'h20);
        check("ovw full", 32'(bus.full), 32'd0);
        compare_all("ovw");

        // ---- clr/load collision in FILLING
        drive(1, 0, 1, 3'd2, 2'd3);
        check("coll V",   32'(bus.V),   32'h0);
        check("coll F2",  32'(bus.F2),  32'd2);
        check("coll ptr", 32'(bus.ptr), 32'd0);
        compare_all("coll");

        // ---- mixed mode
        drive(1, 1, 0, 3'd6, 2'd1);   // ch0 (S ignored)
        drive(1, 1, 0, 3'd6, 2'd2);   // ch1
        drive(1, 0, 0, 3'd7, 2'd3);   // ch7 manual
        check("mix ptr_before", 32'(bus.ptr), 32'd2);
        drive(1, 1, 0, 3'd7, 2'd1);   // ch2 via ptr
        check("mix ptr_after", 32'(bus.ptr), 32'd3);
        check("mix V",         32'(bus.V),   32'h87);
        check("mix F2",        32'(bus.F2),  32'd1);
        check("mix F7",        32'(bus.F7),  32'd3);
        compare_all("mix");

        // ---- load with E changing but load low has no effect
        drive(0, 0, 0, 3'd4, 2'd3);
        compare_all("noload");

        // ---- randomized run against the model
        for (int c = 0; c < 400; c++) begin
            bit ld, au, cl;
            ld = ($urandom_range(0, 9) < 7);
            au = $urandom_range(0, 1) == 1;
            cl = ($urandom_range(0, 29) == 0);
            drive(ld, au, cl, 3'($urandom_range(0, 7)), W'($urandom_range(0, 3)));
            compare_all("rnd");
            if ($urandom_range(0, 79) == 0) begin
                #2 rst = 1'b1;
                #1;
                m_reset();
                compare_all("rnd_rst");
                #1 rst = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_demux_8_reg
